// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned 16x16 multiply / 16/16 divide sequencer.
// Drives the shared ripple ALU for the add or subtract step of each iteration.
module alu_muldiv_sequencer #(
   parameter int WIDTH = 16,
   parameter int ITER  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic             alu_ainvert,
   output logic             alu_bnegate,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout
);

   localparam int CW = $clog2(ITER + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           next;
   logic [CW-1:0]    count;
   logic             divmode;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] nacc;
   logic [WIDTH-1:0] nq;
   logic             last;
   logic             ok;
   logic             carry;
   logic [WIDTH-1:0] sum;

   // Divide step operand: partial remainder shifted left with the next dividend bit.
   assign shifted = {acc[WIDTH-2:0], q[WIDTH-1]};
   assign last    = (count == CW'(ITER - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         IDLE: if (start) next = (mode && (opb == '0)) ? DONE : RUN;
         RUN:  if (last)  next = DONE;
         DONE: next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state == RUN);
      done        = (state == DONE);
      alu_a       = '0;
      alu_b       = '0;
      alu_cin     = 1'b0;
      alu_bnegate = 1'b0;
      alu_op      = 2'b00;
      if (state == RUN) begin
         alu_op = 2'b10;
         alu_b  = m;
         if (divmode) begin
            alu_a       = shifted;
            alu_cin     = 1'b1;
            alu_bnegate = 1'b1;
         end else begin
            alu_a = acc;
         end
      end
   end

   assign alu_ainvert = 1'b0;

   // Next partial product / remainder from the ALU result captured this cycle.
   always_comb begin
      ok    = acc[WIDTH-1] | alu_cout;
      sum   = q[0] ? alu_result : acc;
      carry = q[0] & alu_cout;
      if (divmode) begin
         nacc = ok ? alu_result : shifted;
         nq   = {q[WIDTH-2:0], ok};
      end else begin
         nacc = {carry, sum[WIDTH-1:1]};
         nq   = {sum[0], q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count       <= '0;
         divmode     <= 1'b0;
         acc         <= '0;
         q           <= '0;
         m           <= '0;
         res_lo      <= '0;
         res_hi      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  divmode     <= mode;
                  count       <= '0;
                  acc         <= '0;
                  q           <= opa;
                  m           <= opb;
                  div_by_zero <= 1'b0;
                  if (mode && (opb == '0)) begin
                     res_lo      <= '1;
                     res_hi      <= opa;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               count <= count + 1'b1;
               acc   <= nacc;
               q     <= nq;
               if (last) begin
                  res_hi <= nacc;
                  res_lo <= nq;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer: a behavioural ripple ALU closes
// the loop, and a scoreboard of arithmetic results is checked at each done pulse.
module tb_alu_muldiv_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        mode;
   logic [15:0] opa;
   logic [15:0] opb;
   logic        busy;
   logic        done;
   logic [15:0] res_lo;
   logic [15:0] res_hi;
   logic        div_by_zero;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_cin;
   logic        alu_ainvert;
   logic        alu_bnegate;
   logic [1:0]  alu_op;
   logic [15:0] alu_result;
   logic        alu_cout;

   typedef struct {
      logic [15:0] lo;
      logic [15:0] hi;
      logic        dbz;
      int          lat;
      int          busycyc;
   } exp_t;

   exp_t sb[$];
   int   check_count = 0;
   int   fail_count  = 0;

   alu_muldiv_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .opa(opa), .opb(opb),
      .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi),
      .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_ainvert(alu_ainvert), .alu_bnegate(alu_bnegate), .alu_op(alu_op),
      .alu_result(alu_result), .alu_cout(alu_cout)
   );

   // Stand-in for the datapath ripple ALU: op 2'b10 is a + (b or ~b) + cin.
   logic [16:0] alu_sum;
   assign alu_sum = (alu_op == 2'b10)
                  ? ({1'b0, (alu_ainvert ? ~alu_a : alu_a)} +
                     {1'b0, (alu_bnegate ? ~alu_b : alu_b)} + {16'b0, alu_cin})
                  : 17'b0;
   assign alu_result = alu_sum[15:0];
   assign alu_cout   = alu_sum[16];

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_busy"},   busy,        0);
      checkOutput({tag, "_done"},   done,        0);
      checkOutput({tag, "_res_lo"}, res_lo,      0);
      checkOutput({tag, "_res_hi"}, res_hi,      0);
      checkOutput({tag, "_dbz"},    div_by_zero, 0);
      checkOutput({tag, "_alu_a"},  alu_a,       0);
      checkOutput({tag, "_alu_b"},  alu_b,       0);
      checkOutput({tag, "_cin"},    alu_cin,     0);
      checkOutput({tag, "_ainv"},   alu_ainvert, 0);
      checkOutput({tag, "_bneg"},   alu_bnegate, 0);
      checkOutput({tag, "_op"},     alu_op,      0);
   endtask

   task automatic applyStimulus(input logic m, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [31:0] prod;
      @(negedge clk);
      prod = {16'b0, a} * {16'b0, b};
      if (!m) begin
         e.lo = prod[15:0]; e.hi = prod[31:16]; e.dbz = 1'b0; e.lat = 16; e.busycyc = 16;
      end else if (b == 16'h0) begin
         e.lo = 16'hFFFF; e.hi = a; e.dbz = 1'b1; e.lat = 0; e.busycyc = 0;
      end else begin
         e.lo = a / b; e.hi = a % b; e.dbz = 1'b0; e.lat = 16; e.busycyc = 16;
      end
      sb.push_back(e);
      mode  = m;
      opa   = a;
      opb   = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic runOp(input logic m, input logic [15:0] a, input logic [15:0] b,
                        input int pulse_at, input int reset_at);
      exp_t        e;
      int          j;
      int          busy_cnt;
      bit          got;
      bit          aborted;
      bit          saw_done;
      logic [15:0] held;
      applyStimulus(m, a, b);
      if (!(m && (b == 16'h0))) begin
         checkOutput("run_alu_a",  alu_a,       m ? {16'b0, 15'b0, a[15]} : 32'h0);
         checkOutput("run_alu_b",  alu_b,       b);
         checkOutput("run_cin",    alu_cin,     m);
         checkOutput("run_bneg",   alu_bnegate, m);
         checkOutput("run_op",     alu_op,      2'b10);
      end
      j = 0; busy_cnt = 0; got = 0; aborted = 0;
      while (!got && !aborted && j < 40) begin
         if (done === 1'b1) got = 1;
         else begin
            if (busy === 1'b1) busy_cnt++;
            if (j == pulse_at) begin
               start = 1'b1; mode = ~m; opa = ~a; opb = a ^ b ^ 16'h5A5A;
            end
            if (j == reset_at) reset = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (reset) begin
               reset   = 1'b0;
               aborted = 1;
            end
            j++;
         end
      end
      e = sb.pop_front();
      if (aborted) begin
         checkReset("abort");
         saw_done = 0;
         repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1;
         end
         checkOutput("abort_no_done", saw_done, 0);
      end else begin
         checkOutput("done_seen", got, 1);
         if (got) begin
            checkOutput("latency",    j,           e.lat);
            checkOutput("busy_cycles", busy_cnt,   e.busycyc);
            checkOutput("res_lo",     res_lo,      e.lo);
            checkOutput("res_hi",     res_hi,      e.hi);
            checkOutput("dbz",        div_by_zero, e.dbz);
            checkOutput("done_busy",  busy,        0);
            checkOutput("done_alu_op", alu_op,     0);
            held = res_lo;
            @(negedge clk);
            checkOutput("done_pulse", done,        0);
            checkOutput("hold_lo",    res_lo,      held);
         end
      end
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      clk = 1'b0; reset = 1'b1; start = 1'b0; mode = 1'b0; opa = '0; opb = '0;
      repeat (3) @(negedge clk);
      checkReset("reset");
      reset = 1'b0;

      runOp(1'b0, 16'h00FF, 16'h0101, -1, -1);
      runOp(1'b0, 16'hFFFF, 16'hFFFF, -1, -1);
      runOp(1'b1, 16'd100,  16'd7,    -1, -1);
      runOp(1'b1, 16'hFFFF, 16'h8001, -1, -1);
      runOp(1'b1, 16'h1234, 16'h0000, -1, -1);
      runOp(1'b0, 16'd3,    16'd5,    -1, -1);
      runOp(1'b0, 16'h1234, 16'h0567,  5, -1);
      runOp(1'b1, 16'hBEEF, 16'h0123, -1,  8);
      runOp(1'b0, 16'd2,    16'd3,    -1, -1);
      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = (i == 5) ? 16'h0 : 16'($urandom_range(1, 65535));
         runOp(i[0], ra, rb, -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
